// File: rtl/myfilter_pkg.sv
// ---------------------------------------------------------------------------
// myfilter_pkg
// Shared definitions for the FIR filter controller: sequencer state type,
// register map addresses, serial frame geometry and parameter defaults.
// ---------------------------------------------------------------------------
package myfilter_pkg;

   // Parameter defaults
   localparam int NTAPS_DEF  = 8;
   localparam int DATA_W_DEF = 16;

   // Serial frame geometry: write frame is {ADDR[7:0], DATA[15:0]}
   localparam int FRAME_W = 24;
   localparam int ADDR_W  = 8;
   localparam int FDATA_W = 16;
   localparam int OUT_W   = 16;

   // Register map
   localparam logic [ADDR_W-1:0] CTRL_ADDR   = 8'h10;
   localparam logic [ADDR_W-1:0] STATUS_ADDR = 8'h11;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_MAC   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/filter_ctrl_sio.sv
// ---------------------------------------------------------------------------
// filter_ctrl_sio
// Serial I/O for the filter controller: a 24-bit input frame shifter fed MSB
// first from the I2C slave, and a 16-bit output shifter for read data.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   sde_i         serial data enable (shift both shifters when set)
//   sd_i          serial input bit
//   load_i        load output shifter from load_data_i (wins over shifting)
//   load_data_i   read data to serialise
//   frame_o       current (pre-shift) input frame
//   sd_o          serial output bit = output shifter MSB
// ---------------------------------------------------------------------------
module filter_ctrl_sio
   import myfilter_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sde_i,
   input  logic               sd_i,
   input  logic               load_i,
   input  logic [OUT_W-1:0]   load_data_i,
   output logic [FRAME_W-1:0] frame_o,
   output logic               sd_o
);

   logic [FRAME_W-1:0] in_q;
   logic [OUT_W-1:0]   out_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_q  <= '0;
         out_q <= '0;
      end else begin
         if (sde_i) begin
            in_q <= {in_q[FRAME_W-2:0], sd_i};
         end
         if (load_i) begin
            out_q <= load_data_i;
         end else if (sde_i) begin
            out_q <= {out_q[OUT_W-2:0], 1'b0};
         end
      end
   end

   assign frame_o = in_q;
   assign sd_o    = out_q[OUT_W-1];

endmodule

// File: rtl/filter_ctrl.sv
// ---------------------------------------------------------------------------
// filter_ctrl
// Control block for an FIR filter: serial register access (coefficients held
// in external memory with an internal shadow copy, CTRL and STATUS), a
// coefficient write arbiter with a one-entry pending buffer, and the
// IDLE -> CLEAR -> MAC -> DONE sample sequencer driving the MAC datapath.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   sde_in, sd_in      serial enable / data from I2C slave
//   sd_out             serial read data to I2C slave
//   ul_in, dl_in       upload (write) / download (read) strobes
//   sample_valid_in    new input sample available
//   sample_ready_out   controller can accept a sample
//   coef_*_out         coefficient memory address / write data / write enable
//   mac_clr_out        clear MAC accumulator
//   mac_en_out         MAC accumulate enable
//   result_valid_out   filter output valid pulse
// ---------------------------------------------------------------------------
module filter_ctrl
   import myfilter_pkg::*;
#(
   parameter int NTAPS  = NTAPS_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sde_in,
   input  logic              sd_in,
   output logic              sd_out,
   input  logic              ul_in,
   input  logic              dl_in,
   input  logic              sample_valid_in,
   output logic              sample_ready_out,
   output logic [3:0]        coef_addr_out,
   output logic [DATA_W-1:0] coef_wdata_out,
   output logic              coef_we_out,
   output logic              mac_clr_out,
   output logic              mac_en_out,
   output logic              result_valid_out
);

   logic [FRAME_W-1:0] frame;
   logic [ADDR_W-1:0]  wr_addr;
   logic [FDATA_W-1:0] wr_data;
   logic [ADDR_W-1:0]  rd_addr;
   logic [OUT_W-1:0]   rd_data;

   state_e             state_q;
   logic [3:0]         tap_q;
   logic               ctrl_en_q, ctrl_en_d;
   logic [7:0]         ovr_q, ovr_d;
   logic               pend_q;
   logic [3:0]         pend_addr_q;
   logic [DATA_W-1:0]  pend_data_q;
   logic               we_q;
   logic [3:0]         wr_addr_q;
   logic [DATA_W-1:0]  wr_data_q;
   // Sized to the full 4-bit address space so any address indexes safely;
   // only entries below NTAPS are ever written.
   logic [DATA_W-1:0]  shadow_q [16];

   logic               is_coef_wr;
   logic               busy;
   logic               accept;

   filter_ctrl_sio u_sio (
      .clk         (clk),
      .rst_n       (rst_n),
      .sde_i       (sde_in),
      .sd_i        (sd_in),
      .load_i      (dl_in),
      .load_data_i (rd_data),
      .frame_o     (frame),
      .sd_o        (sd_out)
   );

   // Both frames decode the pre-shift shifter value.
   assign wr_addr = frame[23:16];
   assign wr_data = frame[15:0];
   assign rd_addr = frame[7:0];

   assign is_coef_wr = ul_in && (wr_addr < 8'(NTAPS));
   assign busy       = (state_q != ST_IDLE) || pend_q;

   // In IDLE a pending entry is always committed this cycle, so pend_q alone
   // blocks acceptance.
   assign sample_ready_out = (state_q == ST_IDLE) && ctrl_en_q && !pend_q;
   assign accept           = sample_valid_in && sample_ready_out;

   assign ctrl_en_d = (ul_in && (wr_addr == CTRL_ADDR)) ? wr_data[0] : ctrl_en_q;

   always_comb begin
      ovr_d = ovr_q;
      if (ul_in && (wr_addr == STATUS_ADDR)) begin
         ovr_d = '0;
      end else if (sample_valid_in && !sample_ready_out && ctrl_en_q &&
                   (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 8'd1;
      end
   end

   // Read mux sees the post-write view so a same-cycle upload is returned.
   always_comb begin
      rd_data = '0;
      if (rd_addr < 8'(NTAPS)) begin
         if (is_coef_wr && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
         end else begin
            rd_data = 16'(shadow_q[rd_addr[3:0]]);
         end
      end else if (rd_addr == CTRL_ADDR) begin
         rd_data = {15'd0, ctrl_en_d};
      end else if (rd_addr == STATUS_ADDR) begin
         rd_data = {busy, 7'd0, ovr_d};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         tap_q       <= '0;
         ctrl_en_q   <= 1'b0;
         ovr_q       <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         we_q        <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         for (int i = 0; i < 16; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         ctrl_en_q <= ctrl_en_d;
         ovr_q     <= ovr_d;
         we_q      <= 1'b0;

         if (is_coef_wr) begin
            shadow_q[wr_addr[3:0]] <= DATA_W'(wr_data);
         end

         // Commit a held upload in the first IDLE cycle.
         if ((state_q == ST_IDLE) && pend_q) begin
            we_q      <= 1'b1;
            wr_addr_q <= pend_addr_q;
            wr_data_q <= pend_data_q;
            pend_q    <= 1'b0;
         end

         // A new upload goes straight out only if the memory port is free;
         // otherwise it takes (or overwrites) the pending slot.
         if (is_coef_wr) begin
            if ((state_q == ST_IDLE) && !pend_q) begin
               we_q      <= 1'b1;
               wr_addr_q <= wr_addr[3:0];
               wr_data_q <= DATA_W'(wr_data);
            end else begin
               pend_q      <= 1'b1;
               pend_addr_q <= wr_addr[3:0];
               pend_data_q <= DATA_W'(wr_data);
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (accept) state_q <= ST_CLEAR;
            end
            ST_CLEAR: begin
               tap_q   <= '0;
               state_q <= ST_MAC;
            end
            ST_MAC: begin
               if (tap_q == 4'(NTAPS - 1)) begin
                  state_q <= ST_DONE;
               end else begin
                  tap_q <= tap_q + 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mac_clr_out      = (state_q == ST_CLEAR);
   assign mac_en_out       = (state_q == ST_MAC);
   assign result_valid_out = (state_q == ST_DONE);
   assign coef_we_out      = we_q;
   assign coef_addr_out    = (state_q == ST_MAC) ? tap_q : wr_addr_q;
   assign coef_wdata_out   = wr_data_q;

endmodule

// File: tb/tb_filter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_filter_ctrl
// Directed bench for filter_ctrl: serial register writes/reads, coefficient
// write arbitration, sample sequencing, overrun status, reset behaviour.
// ---------------------------------------------------------------------------
module tb_filter_ctrl;

   localparam int NTAPS  = 8;
   localparam int DATA_W = 16;
   localparam int W      = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sde_in, sd_in, ul_in, dl_in, sample_valid_in;
   logic              sd_out, sample_ready_out, coef_we_out;
   logic              mac_clr_out, mac_en_out, result_valid_out;
   logic [3:0]        coef_addr_out;
   logic [DATA_W-1:0] coef_wdata_out;

   int checks   = 0;
   int errors   = 0;
   int rv_count = 0;

   logic [W-1:0] exp_q[$];     // expected read data
   logic [19:0]  wr_exp_q[$];  // expected coefficient writes {addr, data}
   logic [19:0]  wr_exp;

   filter_ctrl #(.NTAPS(NTAPS), .DATA_W(DATA_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .sde_in           (sde_in),
      .sd_in            (sd_in),
      .sd_out           (sd_out),
      .ul_in            (ul_in),
      .dl_in            (dl_in),
      .sample_valid_in  (sample_valid_in),
      .sample_ready_out (sample_ready_out),
      .coef_addr_out    (coef_addr_out),
      .coef_wdata_out   (coef_wdata_out),
      .coef_we_out      (coef_we_out),
      .mac_clr_out      (mac_clr_out),
      .mac_en_out       (mac_en_out),
      .result_valid_out (result_valid_out)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (result_valid_out) rv_count++;
      if (rst_n && coef_we_out) begin
         check("we_expected", 32'(wr_exp_q.size() > 0), 32'd1);
         if (wr_exp_q.size() > 0) begin
            wr_exp = wr_exp_q.pop_front();
            check("coef_write", {12'd0, coef_addr_out, coef_wdata_out}, {12'd0, wr_exp});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_frame(input logic [23:0] f);
      for (int i = 23; i >= 0; i--) begin
         sde_in = 1'b1;
         sd_in  = f[i];
         tick();
      end
      sde_in = 1'b0;
      sd_in  = 1'b0;
   endtask

   task automatic write_frame(input logic [23:0] f);
      shift_frame(f);
      ul_in = 1'b1;
      tick();
      ul_in = 1'b0;
   endtask

   task automatic read_serial();
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) begin
         v = {v[14:0], sd_out};
         if (i < 15) begin
            sde_in = 1'b1;
            sd_in  = 1'b0;
            tick();
            sde_in = 1'b0;
         end
      end
      check("rd_exp_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("rd_data", {16'd0, v}, {16'd0, exp_q.pop_front()});
   endtask

   task automatic do_read(input logic [7:0] addr, input logic [15:0] exp);
      shift_frame({16'd0, addr});
      exp_q.push_back(exp);
      dl_in = 1'b1;
      tick();
      dl_in = 1'b0;
      read_serial();
   endtask

   task automatic pulse_sample();
      sample_valid_in = 1'b1;
      tick();
      sample_valid_in = 1'b0;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 40 && !sample_ready_out; i++) tick();
      check("wait_ready", {31'd0, sample_ready_out}, 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check(tag, {6'd0, sd_out, sample_ready_out, coef_addr_out, coef_wdata_out,
                  coef_we_out, mac_clr_out, mac_en_out, result_valid_out}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic early;
      logic found;
      int   rv_before;

      rst_n = 1'b0; sde_in = 1'b0; sd_in = 1'b0; ul_in = 1'b0; dl_in = 1'b0;
      sample_valid_in = 1'b0;
      repeat (3) tick();
      check_outputs_zero("reset_outputs");
      rst_n = 1'b1;
      tick();
      check("ready_after_reset", {31'd0, sample_ready_out}, 32'd0);

      // Coefficient write to address 0
      wr_exp_q.push_back({4'h0, 16'h1234});
      write_frame(24'h001234);
      check("s1_we", {31'd0, coef_we_out}, 32'd1);
      check("s1_addr", {28'd0, coef_addr_out}, 32'd0);
      check("s1_wdata", {16'd0, coef_wdata_out}, 32'h1234);
      tick();
      check("s1_we_drop", {31'd0, coef_we_out}, 32'd0);

      // Enable and run one sample
      write_frame(24'h100001);
      check("s2_ready", {31'd0, sample_ready_out}, 32'd1);
      pulse_sample();
      check("s2_clear", {29'd0, mac_clr_out, mac_en_out, result_valid_out}, 32'b100);
      for (int k = 0; k < NTAPS; k++) begin
         tick();
         check("s2_mac_step", {25'd0, mac_clr_out, mac_en_out, result_valid_out, coef_addr_out},
               {25'd0, 3'b010, 4'(k)});
      end
      tick();
      check("s2_done", {29'd0, mac_clr_out, mac_en_out, result_valid_out}, 32'b001);
      tick();
      check("s2_result_pulse", {31'd0, result_valid_out}, 32'd0);
      check("s2_ready_again", {31'd0, sample_ready_out}, 32'd1);

      // Upload to 0x03 during MAC is held until IDLE
      shift_frame(24'h03BEEF);
      pulse_sample();
      tick();
      wr_exp_q.push_back({4'h3, 16'hBEEF});
      ul_in = 1'b1;
      tick();
      ul_in = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 20 && !result_valid_out; i++) begin
         if (coef_we_out) early = 1'b1;
         tick();
      end
      check("s3_no_early_we", {31'd0, early}, 32'd0);
      check("s3_done_seen", {31'd0, result_valid_out}, 32'd1);
      check("s3_we_at_done", {31'd0, coef_we_out}, 32'd0);
      tick();
      check("s3_commit_cycle_we", {31'd0, coef_we_out}, 32'd0);
      check("s3_ready_blocked", {31'd0, sample_ready_out}, 32'd0);
      tick();
      check("s3_held_write", {11'd0, coef_we_out, coef_addr_out, coef_wdata_out},
            {11'd0, 1'b1, 4'h3, 16'hBEEF});
      tick();
      check("s3_single_write", {31'd0, coef_we_out}, 32'd0);
      check("s3_ready", {31'd0, sample_ready_out}, 32'd1);

      // Overrun count while busy, read STATUS during the sequence
      shift_frame(24'h000011);
      pulse_sample();
      repeat (3) begin
         pulse_sample();
         tick();
      end
      exp_q.push_back(16'h8003);
      dl_in = 1'b1;
      tick();
      dl_in = 1'b0;
      check("s4_first_bit", {31'd0, sd_out}, 32'd1);
      read_serial();
      wait_ready();
      write_frame(24'h11FFFF);
      do_read(8'h11, 16'h0000);

      // Unmapped address: no write, reads zero
      write_frame(24'h205555);
      check("s5_no_we", {31'd0, coef_we_out}, 32'd0);
      tick();
      do_read(8'h20, 16'h0000);

      // Readbacks from shadow and CTRL
      do_read(8'h00, 16'h1234);
      do_read(8'h03, 16'hBEEF);
      do_read(8'h10, 16'h0001);

      // Simultaneous upload and download to the same coefficient
      shift_frame(24'h05A505);
      wr_exp_q.push_back({4'h5, 16'hA505});
      exp_q.push_back(16'hA505);
      ul_in = 1'b1;
      dl_in = 1'b1;
      tick();
      ul_in = 1'b0;
      dl_in = 1'b0;
      read_serial();
      do_read(8'h05, 16'hA505);

      // Clearing enable mid-sequence lets it finish, then blocks new samples
      shift_frame(24'h100000);
      pulse_sample();
      tick();
      ul_in = 1'b1;
      tick();
      ul_in = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (result_valid_out) found = 1'b1;
         else tick();
      end
      check("en_clr_completes", {31'd0, found}, 32'd1);
      tick();
      check("en_clr_not_ready", {31'd0, sample_ready_out}, 32'd0);
      pulse_sample();
      check("en_clr_no_accept", {31'd0, mac_clr_out}, 32'd0);
      tick();
      check("en_clr_no_mac", {31'd0, mac_en_out}, 32'd0);
      do_read(8'h10, 16'h0000);

      // Reset during MAC aborts without a result
      write_frame(24'h100001);
      pulse_sample();
      tick();
      tick();
      check("rst_in_mac", {31'd0, mac_en_out}, 32'd1);
      rv_before = rv_count;
      rst_n = 1'b0;
      tick();
      check_outputs_zero("rst_mid_outputs");
      rst_n = 1'b1;
      repeat (15) tick();
      check("rst_no_result", rv_count, rv_before);
      check("rst_ctrl_cleared", {31'd0, sample_ready_out}, 32'd0);
      do_read(8'h03, 16'h0000);

      check("wr_queue_empty", wr_exp_q.size(), 32'd0);
      check("rd_queue_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/filter_ctrl.md
FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 Parameters SHALL be: NTAPS, default 8, number of FIR taps (2..16); DATA_W, default 16, coefficient/register width.
REQ-002 Ports SHALL be:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sde_in  in  1  serial data enable from I2C slave.
- sd_in  in  1  serial data bit from I2C slave, MSB first.
- sd_out  out  1  serial read-data bit to I2C slave.
- ul_in  in  1  upload strobe, one-cycle pulse.
- dl_in  in  1  download strobe, one-cycle pulse.
- sample_valid_in  in  1  new input sample available.
- sample_ready_out  out  1  controller can accept a sample.
- coef_addr_out  out  4  coefficient memory address.
- coef_wdata_out  out  DATA_W  coefficient write data.
- coef_we_out  out  1  coefficient memory write enable.
- mac_clr_out  out  1  clear MAC accumulator.
- mac_en_out  out  1  MAC accumulate enable.
- result_valid_out  out  1  filter output valid, one-cycle pulse.

Function
REQ-003 A 24-bit input shifter SHALL shift left by one, inserting sd_in, on every cycle with sde_in=1.
REQ-004 On ul_in=1, the write frame SHALL be ADDR = shifter[23:16] and DATA = shifter[15:0], using the pre-shift value when sde_in=1 in the same cycle.
REQ-005 The register map SHALL be:
- 0x00..NTAPS-1: coefficients (held in external memory).
- 0x10 CTRL: bit0 = enable; other bits read 0.
- 0x11 STATUS, read-only: bit15 = busy; bits7:0 = overrun count.
- Writes to any other address SHALL be ignored; reads of any other address SHALL return 0.
REQ-006 A coefficient write SHALL drive coef_we_out=1, coef_addr_out=ADDR[3:0] and coef_wdata_out=DATA for one cycle.
REQ-007 Memory arbitration SHALL be:
- MAC sequencing has priority.
- A coefficient upload arriving while state is not IDLE SHALL be held in a one-entry pending buffer and committed in the first IDLE cycle.
- A second upload while one is pending SHALL overwrite the pending entry.
REQ-008 On dl_in=1, a 16-bit output shifter SHALL load the register at ADDR = shifter[7:0]. Coefficient reads SHALL return a shadow copy held inside the block.
REQ-009 sd_out SHALL equal output-shifter bit 15. The output shifter SHALL shift left, filling with 0, on each cycle with sde_in=1 and dl_in=0.
REQ-010 The FSM SHALL have states IDLE, CLEAR, MAC and DONE.
REQ-011 sample_ready_out SHALL be 1 only in IDLE with CTRL.enable=1 and no pending write committing that cycle.
REQ-012 FSM transitions SHALL be:
- IDLE -> CLEAR when sample_valid_in and sample_ready_out are both 1.
- CLEAR (mac_clr_out=1, one cycle) -> MAC.
- MAC: NTAPS cycles, mac_en_out=1, coef_addr_out = tap index 0..NTAPS-1 -> DONE.
- DONE (result_valid_out=1, one cycle) -> IDLE.
REQ-013 Latency from sample acceptance to result_valid_out SHALL be exactly NTAPS+2 cycles.
REQ-014 sample_valid_in=1 while not ready and CTRL.enable=1 SHALL increment the overrun count, saturating at 255. Writing any value to STATUS SHALL clear the count.
REQ-015 Clearing CTRL.enable mid-operation SHALL let the current sequence complete. No new sample SHALL then be accepted.
REQ-016 Simultaneous ul_in and dl_in SHALL perform the write first; the read SHALL return the newly written value.
REQ-017 STATUS.busy SHALL be 1 whenever state is not IDLE or a write is pending.

Reset
REQ-018 When rst_n=0 at a clock edge, the block SHALL reset as follows:
- state = IDLE; pending buffer empty; both shifters = 0; CTRL = 0; overrun count = 0; shadow coefficients = 0.
- All outputs = 0, including sd_out and sample_ready_out.
REQ-019 Reset mid-sequence SHALL abort without asserting result_valid_out.

Structure
REQ-020 The following SHALL live in myfilter_pkg: the state enum type, register address constants (CTRL_ADDR, STATUS_ADDR), frame widths, and the NTAPS/DATA_W defaults.
REQ-021 The serial frame shifter plus output shifter SHALL be one sub-module, filter_ctrl_sio. Sequencer and arbiter logic SHALL remain in filter_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Shift 0x00_1234 then ul_in -> one cycle later coef_we_out=1, coef_addr_out=0, coef_wdata_out=0x1234.
- Write CTRL=1, pulse sample_valid_in -> mac_clr_out for 1 cycle, then mac_en_out for 8 cycles with addresses 0..7, then result_valid_out at cycle 10.
- Upload to 0x03 during the MAC state -> no coef_we_out until IDLE, then a single write of the held value.
- Three sample_valid_in pulses while busy -> STATUS reads 0x8003 via shift 0x11 + dl_in; serial output 1000_0000_0000_0011.
- Write to 0x20 followed by a read of 0x20 -> no memory write occurs, read returns 0x0000.
- Assert rst_n=0 during the MAC state -> all outputs 0 next cycle, and result_valid_out is never asserted.
